// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
//  Package : pcs_pkg
//  Shared 10GBASE-R PCS constants: block geometry, gearbox period and the
//  sync header encodings used by both the encoder and the transmit gearbox.
//  Revision: 1.0 - initial release
// ============================================================================
package pcs_pkg;

    localparam int BLOCK_W   = 64;  // payload bits per 66b block
    localparam int HEAD_W    = 2;   // sync header bits per 66b block
    localparam int GB_PERIOD = 32;  // blocks per gearbox period (33 words)
    localparam int SEQ_W     = 6;   // width of the gearbox sequence counter

    localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;
    localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;

endpackage : pcs_pkg
`default_nettype wire

// File: rtl/pcs_10g_tx_gearbox.sv
`default_nettype none
// ============================================================================
//  Module  : pcs_10g_tx_gearbox
//  10GBASE-R transmit gearbox. Packs 32 x 66-bit blocks ({data, head}, head
//  in the LSBs and sent first) into 33 x 64-bit SerDes words. Every 33rd
//  cycle the leftover register alone forms the output word and upstream is
//  stalled for that cycle.
//
//  Ports:
//    clk      in   SerDes TX parallel clock
//    reset    in   synchronous, active-high reset
//    head_i   in   sync header of the offered block
//    data_i   in   scrambled payload of the offered block
//    valid_i  in   a block is offered on head_i/data_i
//    ready_o  out  block is accepted this cycle (combinational from seq only)
//    data_o   out  packed output word, bit 0 transmitted first
//    valid_o  out  data_o holds a new word
//
//  Revision: 1.0 - initial release
// ============================================================================
module pcs_10g_tx_gearbox #(
    parameter int BLOCK_W = pcs_pkg::BLOCK_W,
    parameter int HEAD_W  = pcs_pkg::HEAD_W,
    parameter int DATA_W  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [HEAD_W-1:0]  head_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [DATA_W-1:0]  data_o,
    output logic               valid_o
);

    import pcs_pkg::*;

    localparam int BLK_TOT = BLOCK_W + HEAD_W;   // 66-bit block
    localparam int CAT_W   = 2 * DATA_W;         // word + leftover window
    localparam int SHAM_W  = 8;                  // holds HEAD_W * GB_PERIOD

    localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(GB_PERIOD);

    // State
    logic [SEQ_W-1:0]  seq_q,   seq_d;
    logic [DATA_W-1:0] buf_q,   buf_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;

    // Datapath
    logic [BLK_TOT-1:0] blk_w;
    logic [SHAM_W-1:0]  shamt_w;
    logic [DATA_W-1:0]  buf_mask_w;
    logic [CAT_W-1:0]   cat_w;
    logic               xfer_w;

    assign blk_w   = {data_i, head_i};
    assign ready_o = (seq_q != SEQ_LAST);
    assign xfer_w  = valid_i && ready_o;

    // seq leftover bits are already in buf; the new block lands just above
    // them. The low half of the window is the output word, the high half is
    // the new leftover (blk[65:64-2k]).
    assign shamt_w    = SHAM_W'(seq_q * HEAD_W);
    assign buf_mask_w = ~({DATA_W{1'b1}} << shamt_w);
    assign cat_w      = ({{(CAT_W-BLK_TOT){1'b0}}, blk_w} << shamt_w)
                      | {{DATA_W{1'b0}}, buf_q & buf_mask_w};

    always_comb begin
        seq_d   = seq_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (!ready_o) begin
            // Catch-up slot: the leftover has grown to a full word.
            data_d  = buf_q;
            buf_d   = '0;
            seq_d   = '0;
            valid_d = 1'b1;
        end else if (xfer_w) begin
            data_d  = cat_w[DATA_W-1:0];
            buf_d   = cat_w[CAT_W-1:DATA_W];
            seq_d   = seq_q + 1'b1;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule : pcs_10g_tx_gearbox
`default_nettype wire

// File: tb/tb_pcs_10g_tx_gearbox.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pcs_10g_tx_gearbox
//  Self-checking bench for pcs_10g_tx_gearbox. Accepted blocks are fed LSB
//  first into a bit-serial reference; every 64 bits it produces become an
//  expected word in a queue that is popped as the gearbox emits words.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_pcs_10g_tx_gearbox;

    logic        clk;
    logic        reset;
    logic [1:0]  head_i;
    logic [63:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] data_o;
    logic        valid_o;

    pcs_10g_tx_gearbox dut (
        .clk     (clk),
        .reset   (reset),
        .head_i  (head_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_total  = 0;
    int          n_bad    = 0;
    int          n_stall  = 0;
    int          n_rdylow = 0;
    bit          bq[$];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Bit-serial reference: shift the 66 block bits in, emit full words.
    task automatic model_push(input logic [65:0] blk);
        logic [63:0] w;
        for (int i = 0; i < 66; i++) bq.push_back(blk[i]);
        while (bq.size() >= 64) begin
            w = '0;
            for (int j = 0; j < 64; j++) w[j] = bq.pop_front();
            exp_q.push_back(w);
        end
    endtask

    // One cycle: check the word from the previous edge, then drive inputs.
    task automatic step(input logic rst, input logic v, input logic [1:0] h,
                        input logic [63:0] d, output logic acc);
        logic [63:0] e;
        @(negedge clk);
        if (valid_o === 1'b1) begin
            obs_q.push_back(data_o);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
            chk("sb_word", data_o, e);
        end
        if (ready_o === 1'b0) n_rdylow++;
        reset   = rst;
        valid_i = v;
        head_i  = h;
        data_i  = d;
        acc = !rst && v && (ready_o === 1'b1);
        if (!rst && v && !acc) n_stall++;
        if (rst) begin
            bq.delete();
            exp_q.delete();
        end else if (acc) begin
            model_push({d, h});
        end
    endtask

    task automatic send(input logic [1:0] h, input logic [63:0] d);
        logic acc;
        int   tries = 0;
        do begin
            step(1'b0, 1'b1, h, d, acc);
            tries++;
        end while (!acc && tries < 4);
        if (!acc) chk("send_timeout", {63'b0, acc}, 64'd1);
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 64'h0, acc);
    endtask

    task automatic do_reset();
        logic acc;
        step(1'b1, 1'b0, 2'b00, 64'h0, acc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [63:0] one;
    logic [63:0] blk_b;
    logic [1:0]  hb;
    logic [63:0] db;
    logic        acc;
    logic        have;
    logic [1:0]  ph;
    logic [63:0] pd;
    int          sent;

    initial begin
        one     = 64'h1;
        reset   = 1'b1;
        valid_i = 1'b0;
        head_i  = 2'b00;
        data_i  = 64'h0;

        // Reset state
        do_reset();
        do_reset();
        step(1'b0, 1'b0, 2'b00, 64'h0, acc);
        chk("rst_data",  data_o, 64'h0);
        chk("rst_valid", {63'b0, valid_o}, 64'd0);
        chk("rst_ready", {63'b0, ready_o}, 64'd1);

        // Two full-rate periods: zero payloads, then block 31 = DEADBEEF...
        // Block 0 of the second period is offered during the catch-up slot.
        obs_q.delete();
        n_stall  = 0;
        n_rdylow = 0;
        for (int k = 0; k < 32; k++) send(2'b01, 64'h0);
        for (int k = 0; k < 32; k++)
            send(2'b01, (k == 31) ? 64'hDEAD_BEEF_0123_4567 : 64'h0);
        drain(4);
        chk("t2_nwords", 64'(obs_q.size()), 64'd66);
        if (obs_q.size() == 66) begin
            for (int k = 0; k < 32; k++) chk("t2_word", obs_q[k], one << (2 * k));
            chk("t2_word32", obs_q[32], 64'h0);
            chk("t5_held_w0", obs_q[33], 64'h1);
            chk("t3_word31", obs_q[64], 64'h4000_0000_0000_0000);
            chk("t3_word32", obs_q[65], 64'hDEAD_BEEF_0123_4567);
        end
        chk("t5_stall", 64'(n_stall), 64'd1);
        chk("t2_rdylow", 64'(n_rdylow), 64'd2);

        // Three-cycle bubble at seq = 10
        do_reset();
        obs_q.delete();
        for (int k = 0; k < 10; k++) send(2'b01, 64'h0);
        step(1'b0, 1'b0, 2'b00, 64'h0, acc);
        step(1'b0, 1'b0, 2'b00, 64'h0, acc);
        chk("t4_bubble1", {63'b0, valid_o}, 64'd0);
        step(1'b0, 1'b0, 2'b00, 64'h0, acc);
        chk("t4_bubble2", {63'b0, valid_o}, 64'd0);
        step(1'b0, 1'b1, 2'b01, 64'h0, acc);
        chk("t4_bubble3", {63'b0, valid_o}, 64'd0);
        chk("t4_resume", {63'b0, acc}, 64'd1);
        for (int k = 11; k < 32; k++) send(2'b01, 64'h0);
        drain(4);
        chk("t4_nwords", 64'(obs_q.size()), 64'd33);
        if (obs_q.size() == 33) begin
            for (int k = 0; k < 32; k++) chk("t4_word", obs_q[k], one << (2 * k));
            chk("t4_word32", obs_q[32], 64'h0);
        end

        // Reset in mid-period discards the leftover
        do_reset();
        for (int k = 0; k < 17; k++) send(2'($urandom), {$urandom, $urandom});
        do_reset();
        obs_q.delete();
        hb = 2'b10;
        db = {$urandom, $urandom};
        blk_b = {db[61:0], hb};
        send(hb, db);
        drain(3);
        chk("t6_nwords", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0) chk("t6_first", obs_q[0], blk_b);

        // Random traffic against the bit-serial reference
        do_reset();
        have = 1'b0;
        ph   = 2'b00;
        pd   = 64'h0;
        sent = 0;
        while (sent < 10000) begin
            if (!have && $urandom_range(0, 4) != 0) begin
                have = 1'b1;
                ph   = 2'($urandom);
                pd   = {$urandom, $urandom};
            end
            step(1'b0, have, ph, pd, acc);
            if (acc) begin
                have = 1'b0;
                sent++;
            end
        end
        drain(40);
        chk("rand_left", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pcs_10g_tx_gearbox
`default_nettype wire
